data_packer_n: RTL and testbench

- Parametrised successor to the byte data packer: gathers 1..MAX_RATIO narrow AXI-Stream beats into one wide output word.
- Packing ratio is runtime-selectable per packet via k.
- Short packets and packet tails are flushed on tlast, with a per-lane keep mask.
- Sits between the byte-wide ingress stream and the wide datapath/DMA side; includes a registered output stage.

---
 rtl/data_packer_n.sv | 126 ++++++++++++
 tb/tb_data_packer_n.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_packer_n.sv
// Gathers 1..MAX_RATIO narrow AXI-Stream beats into one wide word, ratio chosen per packet.
// Packet tails are flushed on tlast with a per-lane keep mask; the output stage is registered.
module data_packer_n #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_RATIO  = 4,
    parameter int K_WIDTH    = $clog2(MAX_RATIO)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [K_WIDTH-1:0]              k,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [DATA_WIDTH*MAX_RATIO-1:0] m_axis_tdata,
    output logic [MAX_RATIO-1:0]            m_axis_tkeep,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy
);

    localparam int WORD_WIDTH = DATA_WIDTH * MAX_RATIO;

    typedef enum logic {
        ST_IDLE,
        ST_OPEN
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;

    logic [K_WIDTH-1:0]      r_idx;
    logic [K_WIDTH-1:0]      r_ratio;
    logic [WORD_WIDTH-1:0]   r_acc;

    logic [WORD_WIDTH-1:0]   r_outData;
    logic [MAX_RATIO-1:0]    r_outKeep;
    logic                    r_outLast;
    logic                    r_outValid;

    logic                    w_accept;
    logic [K_WIDTH-1:0]      w_ratio;
    logic                    w_complete;
    logic [WORD_WIDTH-1:0]   w_merged;
    logic [MAX_RATIO-1:0]    w_keep;

    assign s_axis_tready = !r_outValid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    // The first beat of a packet must already obey the incoming k, before it is latched.
    assign w_ratio    = (r_state == ST_OPEN) ? r_ratio : k;
    assign w_complete = w_accept && ((r_idx == w_ratio) || s_axis_tlast);

    always_comb begin
        w_merged = r_acc;
        w_keep   = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            if (r_idx == K_WIDTH'(i)) begin
                w_merged[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
            end
            w_keep[i] = (K_WIDTH'(i) <= r_idx);
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_accept) begin
            w_nextState = s_axis_tlast ? ST_IDLE : ST_OPEN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ratio <= '0;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            r_ratio <= k;
        end
    end

    // Lane index wraps explicitly at the latched ratio rather than by counter overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (w_complete) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + K_WIDTH'(1);
            r_acc <= w_merged;
        end
    end

    // A completion may reload the register in the same cycle the old word drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outData  <= '0;
            r_outKeep  <= '0;
            r_outLast  <= 1'b0;
            r_outValid <= 1'b0;
        end else if (w_complete) begin
            r_outData  <= w_merged;
            r_outKeep  <= w_keep;
            r_outLast  <= s_axis_tlast;
            r_outValid <= 1'b1;
        end else if (m_axis_tready) begin
            r_outValid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_outData;
    assign m_axis_tkeep  = r_outKeep;
    assign m_axis_tlast  = r_outLast;
    assign m_axis_tvalid = r_outValid;
    assign busy          = (r_state == ST_OPEN);

endmodule

// File: tb/tb_data_packer_n.sv
// Scoreboard bench for data_packer_n: packets are chunked into expected words by a simple
// model at issue time, and a negedge monitor pops and compares whatever the DUT presents.
module tb_data_packer_n;

    localparam int DW = 8;
    localparam int MR = 4;
    localparam int KW = 2;
    localparam int WW = DW * MR;

    typedef logic [7:0] byteQ_t[$];

    typedef struct {
        logic [WW-1:0] data;
        logic [MR-1:0] keep;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [KW-1:0] k;
    logic [DW-1:0] sData;
    logic          sValid;
    logic          sReady;
    logic          sLast;
    logic [WW-1:0] mData;
    logic [MR-1:0] mKeep;
    logic          mValid;
    logic          mReady;
    logic          mLast;
    logic          busy;

    exp_t expQ[$];
    exp_t monExp;
    int   errors = 0;
    int   checks = 0;
    bit   randReady = 1'b0;

    data_packer_n #(.DATA_WIDTH(DW), .MAX_RATIO(MR), .K_WIDTH(KW)) dut (
        .clk           (clk),
        .reset         (reset),
        .k             (k),
        .s_axis_tdata  (sData),
        .s_axis_tvalid (sValid),
        .s_axis_tready (sReady),
        .s_axis_tlast  (sLast),
        .m_axis_tdata  (mData),
        .m_axis_tkeep  (mKeep),
        .m_axis_tvalid (mValid),
        .m_axis_tready (mReady),
        .m_axis_tlast  (mLast),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference: a packet of n bytes at ratio r becomes ceil(n/r) words, little-endian lanes.
    task automatic pushPacket(input int r, input byteQ_t b);
        int n;
        n = b.size();
        for (int s = 0; s < n; s += r) begin
            int   cnt;
            exp_t e;
            cnt    = (n - s < r) ? (n - s) : r;
            e.data = '0;
            for (int j = 0; j < cnt; j++) begin
                e.data = e.data | (WW'(b[s+j]) << (8 * j));
            end
            e.keep = MR'((1 << cnt) - 1);
            e.last = (s + cnt == n);
            expQ.push_back(e);
        end
    endtask

    task automatic sendBeat(input logic [7:0] d, input logic last);
        int t;
        t      = 0;
        sData  = d;
        sLast  = last;
        sValid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!sReady && t < 300);
        if (!sReady) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        sValid = 1'b0;
        sLast  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [KW-1:0] kVal, input byteQ_t b, input int gapMax,
                                 input int kChangeAfter, input logic [KW-1:0] kNew, input int stallAfter);
        int r;
        int n;
        r = int'(kVal) + 1;
        n = b.size();
        pushPacket(r, b);
        k = kVal;
        for (int p = 0; p < n; p++) begin
            bit lastBeat;
            bit completes;
            lastBeat  = (p == n - 1);
            completes = ((p % r) == r - 1) || lastBeat;
            if (gapMax > 0) begin
                repeat ($urandom_range(0, gapMax)) begin
                    @(posedge clk);
                    #1;
                end
            end
            sendBeat(b[p], lastBeat);
            checkOutput("busy", 64'(busy), 64'(!lastBeat));
            if (!randReady && completes) checkOutput("latency_tvalid", 64'(mValid), 64'd1);
            if (p + 1 == kChangeAfter) k = kNew;
            if (p + 1 == stallAfter && !lastBeat) begin
                mReady = 1'b0;
                sData  = b[p+1];
                sLast  = (p + 1 == n - 1);
                sValid = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                mReady = 1'b1;
            end
        end
    endtask

    task automatic drainWait();
        int t;
        t = 0;
        while (expQ.size() > 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: reset values while in reset, otherwise compare the presented word to the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("reset_tvalid", 64'(mValid), 64'd0);
            checkOutput("reset_tdata", 64'(mData), 64'd0);
            checkOutput("reset_tkeep", 64'(mKeep), 64'd0);
            checkOutput("reset_tlast", 64'(mLast), 64'd0);
            checkOutput("reset_busy", 64'(busy), 64'd0);
        end else begin
            checkOutput("s_tready_rule", 64'(sReady), 64'(!mValid || mReady));
            if (mValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", 64'(mData), 64'hDEAD_BEEF_0000_0000);
                    if (mReady) checks = checks;
                end else begin
                    monExp = expQ[0];
                    checkOutput("tdata", 64'(mData), 64'(monExp.data));
                    checkOutput("tkeep", 64'(mKeep), 64'(monExp.keep));
                    checkOutput("tlast", 64'(mLast), 64'(monExp.last));
                    if (mReady) void'(expQ.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randReady) mReady = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byteQ_t b;
        reset  = 1'b1;
        k      = '0;
        sData  = '0;
        sValid = 1'b0;
        sLast  = 1'b0;
        mReady = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        checkOutput("post_reset_busy", 64'(busy), 64'd0);

        $display("[TB] ratio 4 full word");
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(2'd3, b, 0, -1, 2'd0, -1);

        $display("[TB] ratio 4 six-byte packet with tail");
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        applyStimulus(2'd3, b, 0, -1, 2'd0, -1);

        $display("[TB] ratio 1 back-to-back");
        b = '{8'hAA, 8'hBB};
        applyStimulus(2'd0, b, 0, -1, 2'd0, -1);

        $display("[TB] ratio 2 with downstream stall");
        b = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(2'd1, b, 0, -1, 2'd0, 2);

        $display("[TB] k change mid-packet ignored");
        b = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(2'd1, b, 0, 2, 2'd3, -1);
        b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        applyStimulus(k, b, 0, -1, 2'd0, -1);
        drainWait();

        $display("[TB] reset mid-packet");
        k = 2'd3;
        sendBeat(8'hA1, 1'b0);
        sendBeat(8'hA2, 1'b0);
        checkOutput("busy_open", 64'(busy), 64'd1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        b = '{8'h55, 8'h66, 8'h77, 8'h88};
        applyStimulus(2'd3, b, 0, -1, 2'd0, -1);
        drainWait();

        $display("[TB] randomized packets");
        randReady = 1'b1;
        for (int pk = 0; pk < 60; pk++) begin
            int n;
            n = $urandom_range(1, 9);
            b = {};
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            applyStimulus(KW'($urandom_range(0, 3)), b, 2, $urandom_range(1, n), KW'($urandom_range(0, 3)), -1);
        end
        randReady = 1'b0;
        @(posedge clk);
        #2;
        mReady = 1'b1;
        drainWait();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
